// File: rtl/occupancy_counter.sv
// Lot occupancy counter with edge-detected enter/exit events, a status FSM and sticky faults.
// Latency 1 from event edge to count/flags; optional peak register under PEAK_TRACK_EN.
module occupancy_counter #(
  parameter int CAPACITY  = 16,
  parameter int CNT_W     = 5,
  parameter int NEAR_FULL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             car_enter,
  input  logic             car_exit,
  input  logic             clr,
  input  logic             err_clr,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] free,
  output logic             empty,
  output logic             near_full,
  output logic             full,
  output logic             entry_allow,
  output logic             err_overflow,
`ifdef PEAK_TRACK_EN
  output logic [CNT_W-1:0] peak,
`endif
  output logic             err_underflow
);

  localparam logic [CNT_W-1:0] CAP_C   = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(CAPACITY - NEAR_FULL);

  typedef enum logic [1:0] {
    ST_OPEN    = 2'd0,
    ST_LIMITED = 2'd1,
    ST_FULL    = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] free_q;
  logic             empty_q, full_q, near_full_q, entry_allow_q;
  logic             err_ovf_q, err_ovf_d;
  logic             err_unf_q, err_unf_d;
  logic             enter_q, exit_q;
  logic             inc, dec;
  logic             ovf_set, unf_set;
  state_t           count_state;

  assign inc = car_enter & ~enter_q;
  assign dec = car_exit & ~exit_q;

  always_comb begin
    count_d = count_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (inc && dec) begin
      count_d = count_q;
    end else if (inc) begin
      if (count_q < CAP_C) count_d = count_q + 1'b1;
      else                 ovf_set = 1'b1;
    end else if (dec) begin
      if (count_q != '0) count_d = count_q - 1'b1;
      else               unf_set = 1'b1;
    end
  end

  // A fault raised in the same cycle as err_clr must survive the clear.
  assign err_ovf_d = ovf_set | (err_ovf_q & ~err_clr);
  assign err_unf_d = unf_set | (err_unf_q & ~err_clr);

  always_comb begin
    count_state = ST_OPEN;
    if (count_d == CAP_C)       count_state = ST_FULL;
    else if (count_d >= LIMIT_C) count_state = ST_LIMITED;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OPEN, ST_LIMITED, ST_FULL: begin
        if (err_ovf_d || err_unf_d) state_d = ST_FAULT;
        else                        state_d = count_state;
      end
      ST_FAULT: begin
        if (!err_ovf_d && !err_unf_d) state_d = count_state;
      end
      default: state_d = ST_FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_OPEN;
      count_q       <= '0;
      free_q        <= CAP_C;
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
      near_full_q   <= 1'b0;
      entry_allow_q <= 1'b1;
      err_ovf_q     <= 1'b0;
      err_unf_q     <= 1'b0;
      enter_q       <= 1'b0;
      exit_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      free_q        <= CAP_C - count_d;
      empty_q       <= (count_d == '0);
      full_q        <= (count_d == CAP_C);
      near_full_q   <= (state_d == ST_LIMITED);
      entry_allow_q <= (state_d == ST_OPEN) || (state_d == ST_LIMITED);
      err_ovf_q     <= err_ovf_d;
      err_unf_q     <= err_unf_d;
      enter_q       <= car_enter;
      exit_q        <= car_exit;
    end
  end

`ifdef PEAK_TRACK_EN
  logic [CNT_W-1:0] peak_q;

  // High-water mark survives clr and err_clr; only rst clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      peak_q <= '0;
    end else if (count_d > peak_q) begin
      peak_q <= count_d;
    end
  end

  assign peak = peak_q;
`endif

  assign count         = count_q;
  assign free          = free_q;
  assign empty         = empty_q;
  assign full          = full_q;
  assign near_full     = near_full_q;
  assign entry_allow   = entry_allow_q;
  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_unf_q;

endmodule

// File: tb/tb_occupancy_counter.sv
// Self-checking bench for occupancy_counter: per-cycle scoreboard against a behavioural model
// plus fixed-value checks at the scenario milestones.
module tb_occupancy_counter;

  localparam int CAP = 16;
  localparam int NF  = 2;
  localparam int W   = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         car_enter = 1'b0;
  logic         car_exit = 1'b0;
  logic         clr = 1'b0;
  logic         err_clr = 1'b0;
  logic [W-1:0] count, free;
  logic         empty, near_full, full, entry_allow, err_overflow, err_underflow;
`ifdef PEAK_TRACK_EN
  logic [W-1:0] peak;
`endif

  occupancy_counter #(.CAPACITY(CAP), .CNT_W(W), .NEAR_FULL(NF)) dut (
    .clk          (clk),
    .rst          (rst),
    .car_enter    (car_enter),
    .car_exit     (car_exit),
    .clr          (clr),
    .err_clr      (err_clr),
    .count        (count),
    .free         (free),
    .empty        (empty),
    .near_full    (near_full),
    .full         (full),
    .entry_allow  (entry_allow),
    .err_overflow (err_overflow),
`ifdef PEAK_TRACK_EN
    .peak         (peak),
`endif
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] count;
    logic [31:0] free;
    logic [31:0] empty;
    logic [31:0] full;
    logic [31:0] near_full;
    logic [31:0] entry_allow;
    logic [31:0] ovf;
    logic [31:0] unf;
    logic [31:0] peak;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state
  int m_count = 0;
  int m_peak  = 0;
  bit m_pe = 0, m_px = 0, m_ovf = 0, m_unf = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit en, input bit ex, input bit c, input bit ec, input bit r);
    bit inc, dec, oset, uset;
    int nc;
    exp_t e;
    bit lim;
    inc = en & ~m_pe;
    dec = ex & ~m_px;
    if (!r) begin
      m_count = 0; m_pe = 0; m_px = 0; m_ovf = 0; m_unf = 0; m_peak = 0;
    end else begin
      oset = 0; uset = 0; nc = m_count;
      if (c) nc = 0;
      else if (inc && dec) nc = m_count;
      else if (inc) begin
        if (m_count < CAP) nc = m_count + 1; else oset = 1;
      end else if (dec) begin
        if (m_count > 0) nc = m_count - 1; else uset = 1;
      end
      m_ovf = oset | (m_ovf & ~ec);
      m_unf = uset | (m_unf & ~ec);
      m_count = nc;
      m_pe = en; m_px = ex;
      if (nc > m_peak) m_peak = nc;
    end
    lim = !(m_ovf || m_unf) && (m_count < CAP) && (m_count >= CAP - NF);
    e.count       = m_count;
    e.free        = CAP - m_count;
    e.empty       = (m_count == 0);
    e.full        = (m_count == CAP);
    e.near_full   = lim;
    e.entry_allow = !(m_ovf || m_unf) && (m_count < CAP);
    e.ovf         = m_ovf;
    e.unf         = m_unf;
    e.peak        = m_peak;
    exp_q.push_back(e);
  endtask

  task automatic compare_outputs();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check("count", count, e.count);
    check("free", free, e.free);
    check("empty", empty, e.empty);
    check("full", full, e.full);
    check("near_full", near_full, e.near_full);
    check("entry_allow", entry_allow, e.entry_allow);
    check("err_overflow", err_overflow, e.ovf);
    check("err_underflow", err_underflow, e.unf);
`ifdef PEAK_TRACK_EN
    check("peak", peak, e.peak);
`endif
  endtask

  // One clock: drive inputs away from the edge, predict, then compare 1 time unit after the edge.
  task automatic cyc(input bit en, input bit ex, input bit c, input bit ec, input bit r);
    car_enter = en; car_exit = ex; clr = c; err_clr = ec; rst = r;
    model_step(en, ex, c, ec, r);
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_count"}, count, 0);
    check({tag, "_free"}, free, CAP);
    check({tag, "_empty"}, empty, 1);
    check({tag, "_full"}, full, 0);
    check({tag, "_near_full"}, near_full, 0);
    check({tag, "_entry_allow"}, entry_allow, 1);
    check({tag, "_ovf"}, err_overflow, 0);
    check({tag, "_unf"}, err_underflow, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    check_reset_values("reset");

    // Three spaced pulses
    pulses(3);
    check("three_count", count, 3);
    check("three_free", free, 13);
    check("three_empty", empty, 0);
    check("three_allow", entry_allow, 1);

    // Held input counts once
    repeat (5) cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    check("held_count", count, 4);

    pulses(10);
    check("fill14_count", count, 14);
    check("fill14_near_full", near_full, 1);
    pulses(2);
    check("fill16_full", full, 1);
    check("fill16_allow", entry_allow, 0);
    pulses(1);
    check("ovf_count", count, 16);
    check("ovf_flag", err_overflow, 1);
    check("ovf_allow", entry_allow, 0);
    cyc(0, 0, 0, 1, 1);
    check("ovf_clr_flag", err_overflow, 0);
    check("ovf_clr_full", full, 1);
    check("ovf_clr_near", near_full, 0);
    check("ovf_clr_allow", entry_allow, 0);

    // Simultaneous enter/exit while full
    cyc(1, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    check("sim16_count", count, 16);
    check("sim16_ovf", err_overflow, 0);

    // Underflow from empty, clr keeps flag, set beats err_clr
    cyc(0, 0, 1, 0, 1);
    check("clr_count", count, 0);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    check("unf_count", count, 0);
    check("unf_flag", err_underflow, 1);
    check("unf_allow", entry_allow, 0);
    cyc(0, 0, 1, 0, 1);
    check("unf_survives_clr", err_underflow, 1);
    cyc(0, 1, 0, 1, 1);
    check("unf_set_wins", err_underflow, 1);
    cyc(0, 0, 0, 1, 1);
    check("unf_cleared", err_underflow, 0);
    check("unf_clr_allow", entry_allow, 1);

    // Simultaneous enter/exit at 5
    pulses(5);
    cyc(1, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    check("sim5_count", count, 5);

    // Fresh lot: clr against an entry edge, then mid-operation reset
    cyc(0, 0, 0, 0, 0);
    pulses(9);
    check("pre_clr_count", count, 9);
    cyc(1, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 1);
    check("clr_with_inc", count, 0);
`ifdef PEAK_TRACK_EN
    check("peak_after_clr", peak, 9);
`endif
    pulses(4);
    check("pre_rst_count", count, 4);
    cyc(1, 0, 0, 0, 0);
    check_reset_values("rst_mid");
`ifdef PEAK_TRACK_EN
    check("peak_after_rst", peak, 0);
`endif
    // Input already high at the first edge after reset counts once
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    check("post_rst_high_in", count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/occupancy_counter.md
Name: occupancy_counter

Overview:
Downstream consumer of the vehicle access FSM's car_enter/car_exit outputs. Maintains the lot occupancy count against a fixed capacity and runs a small lot-status state machine. Drives occupancy flags, an entry-permit signal for the gate/sign logic, and sticky overflow/underflow fault flags.

Parameters:
CAPACITY, 16, number of parking spaces; legal range 2..(2^CNT_W - 1).
CNT_W, 5, width of count/free/peak; must hold CAPACITY.
NEAR_FULL, 2, remaining-space threshold for LIMITED; legal range 1..CAPACITY-1.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous active-low reset.
car_enter  input  1  entry-complete indication from the access FSM.
car_exit  input  1  exit-complete indication from the access FSM.
clr  input  1  synchronous count clear (operator reset of the lot).
err_clr  input  1  clears the sticky fault flags.
count  output  CNT_W  current occupancy.
free  output  CNT_W  CAPACITY - count.
empty  output  1  count == 0.
near_full  output  1  state == LIMITED.
full  output  1  count == CAPACITY.
entry_allow  output  1  high in OPEN or LIMITED.
err_overflow  output  1  sticky: an entry arrived while full.
err_underflow  output  1  sticky: an exit arrived while empty.
peak  output  CNT_W  present only with PEAK_TRACK_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-low. rst low at a clock edge overrides every other input, including mid-operation.
- Reset values: count=0, free=CAPACITY, empty=1, full=0, near_full=0, entry_allow=1, err_overflow=0, err_underflow=0, state=OPEN, edge registers=0.
- Edge detect:
  - enter_d and exit_d register the previous input samples.
  - inc = car_enter & ~enter_d; dec = car_exit & ~exit_d.
  - An input held high counts once.
  - Because the edge registers reset to 0, an input already high at the first edge after reset counts once.
- Count update happens on the same edge that samples the event, so it is visible the next cycle (latency 1). Priority, first match wins:
  - clr=1: count=0; inc/dec are ignored; edge registers still update.
  - inc & dec: count unchanged, no error, even when full or empty.
  - inc only, count<CAPACITY: count+1.
  - inc only, count==CAPACITY: count held; err_overflow set.
  - dec only, count>0: count-1.
  - dec only, count==0: count held at 0 (no wrap); err_underflow set.
- Fault flags:
  - err_clr clears both flags.
  - If a set condition and err_clr occur in the same cycle, set wins.
  - clr does not clear the flags.
- Status FSM (registered; next state is computed from the next count and next flags, so state is always consistent with count):
  - OPEN: count_next < CAPACITY-NEAR_FULL.
  - LIMITED: CAPACITY-NEAR_FULL <= count_next < CAPACITY.
  - FULL: count_next == CAPACITY.
  - FAULT: entered from any state when either fault flag is (or becomes) set; it has priority over the count-based states.
  - FAULT is left only when both flags are clear. The exit target is selected by count_next.
- Outputs:
  - All outputs are registered.
  - free, empty and full derive from the registered count.
  - entry_allow = OPEN or LIMITED; it is 0 in FULL and FAULT.

Optional Feature:
Macro PEAK_TRACK_EN.
- Defined:
  - Adds output peak, reset to 0.
  - Each edge: peak = max(peak, count_next).
  - Not cleared by clr or err_clr; cleared only by rst.
- Undefined: no peak port and no peak register. All other behaviour is identical.

Test Plan:
- Reset, then three single-cycle car_enter pulses spaced 2 cycles apart -> count=3, free=13, empty=0, state OPEN, entry_allow=1.
- car_enter held high for 5 cycles -> count increments by exactly 1.
- CAPACITY=16, NEAR_FULL=2; fill from 0:
  - count=14 -> near_full=1.
  - count=16 -> full=1, entry_allow=0.
  - 17th entry -> count=16, err_overflow=1, state FAULT.
  - err_clr -> state FULL, err_overflow=0.
- count=0, then car_exit pulse -> count stays 0, err_underflow=1, entry_allow=0 -> err_clr -> state OPEN, entry_allow=1.
- Simultaneous-event boundaries:
  - count=5 with car_enter and car_exit rising on the same edge -> count=5.
  - Same at count=16 -> count=16, no error.
- Clear and reset:
  - count=9, clr=1 with a car_enter edge in the same cycle -> count=0.
  - Then rst=0 for one edge at count=4 -> all outputs return to reset values.
  - With PEAK_TRACK_EN, peak holds 9 across clr and returns to 0 after rst.
